uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 87, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port: i_Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_Tx_DV  input  1  byte-valid strobe; a byte is accepted on a cycle where i_Tx_DV=1 and o_Tx_Ready=1.
REQ-005 SHALL have port: i_Tx_Byte  input  8  byte to send; sampled only on acceptance.
REQ-006 SHALL have port: o_Tx_Ready  output  1  high when a byte can be accepted (holding register empty).
REQ-007 SHALL have port: o_Tx_Active  output  1  high while a frame (start..stop) is on the line.
REQ-008 SHALL have port: o_Tx_Serial  output  1  serial line, idle high.
REQ-009 SHALL have port: o_Tx_Done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-010 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 SHALL hold every bit on o_Tx_Serial for exactly CLKS_PER_BIT cycles; a full frame is 10*CLKS_PER_BIT cycles.
REQ-012 SHALL implement states IDLE, START, DATA, STOP; no other state reachable; any illegal encoding goes to IDLE next cycle.
REQ-013 SHALL contain a one-entry holding register plus a shift register; o_Tx_Ready = holding register empty.
REQ-014 SHALL, in IDLE with a byte accepted, load it directly into the shift register and enter START on the next edge (o_Tx_Serial low from the cycle after acceptance); holding register stays empty.
REQ-015 SHALL, in START/DATA/STOP with a byte accepted, store it in the holding register; o_Tx_Ready drops the following cycle.
REQ-016 SHALL, in DATA, use a 3-bit bit index 0..7 and advance after CLKS_PER_BIT cycles; after bit 7 enter STOP.
REQ-017 SHALL, on the last STOP cycle, pulse o_Tx_Done; if holding register is full, move it to the shift register, clear the holding register and enter START next cycle (back-to-back, zero idle cycles); else enter IDLE.
REQ-018 SHALL accept a byte on the last STOP cycle into the holding register only if it was empty; if it was empty, that byte is the one started next (no gap).
REQ-019 SHALL hold o_Tx_Serial high in IDLE and STOP; o_Tx_Active=1 in START, DATA, STOP, 0 in IDLE.
REQ-020 SHALL ignore i_Tx_DV when o_Tx_Ready=0 (byte dropped, no state change).
REQ-021 SHALL register o_Tx_Serial (no combinational path from i_Tx_DV or i_Tx_Byte to o_Tx_Serial).
REQ-022 SHALL use a bit-time counter wide enough for CLKS_PER_BIT-1 at max parameter value, reset to 0 on every bit boundary.

Reset
REQ-023 SHALL, with i_Reset=1 at a clock edge, enter IDLE, clear the counters, shift and holding registers, and drive o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1 from the next cycle.
REQ-024 SHALL let reset take priority over acceptance; a byte presented with i_Reset=1 is discarded.
REQ-025 SHALL, on reset mid-frame, abort immediately (line returns high next cycle); no o_Tx_Done pulse for the aborted frame.

Verification
REQ-026 SHALL verify single byte: CLKS_PER_BIT=87, accept 0x3F in IDLE -> line 0,1,1,1,1,1,1,0,0,1, each 87 cycles, o_Tx_Done one pulse at cycle 870 after acceptance, then idle high.
REQ-027 SHALL verify back-to-back: accept 0xA5 then 0x5A during first frame -> second start bit begins the cycle after the first o_Tx_Done, o_Tx_Active never drops between frames.
REQ-028 SHALL verify overflow: with holding register full, pulse i_Tx_DV with 0xFF -> byte dropped, only the two earlier bytes transmitted.
REQ-029 SHALL verify reset mid-frame: assert i_Reset during data bit 3 of 0x00 -> o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Ready=1 next cycle, no o_Tx_Done.
REQ-030 SHALL verify loopback: connect o_Tx_Serial to the team's UART receiver with equal CLKS_PER_BIT, send 0x00, 0xFF, 0x55, 0x81 -> receiver outputs the same bytes in order, one valid pulse each.
REQ-031 SHALL verify minimum parameter: CLKS_PER_BIT=2, send 0xC3 -> 20-cycle frame, correct bit pattern.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for the UART transmitter.
// Signal names follow the transmitter's established pin names.
interface uart_tx_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;

    // Byte producer side
    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    // Transmitter side
    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so a second byte can be
// queued during a frame and sent back-to-back with no idle bit between frames.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic     i_Clock,
    input  logic     i_Reset,
    uart_tx_if.slave tx
);

    // 16 bits covers CLKS_PER_BIT-1 up to 65534
    localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        serial_q, serial_d;

    logic accept;
    logic bit_end;

    assign accept  = tx.i_Tx_DV & ~hold_full_q;
    assign bit_end = (cnt_q == BitLast);

    assign tx.o_Tx_Ready  = ~hold_full_q;
    assign tx.o_Tx_Active = (state_q != StIdle);
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Done   = (state_q == StStop) & bit_end;

    // Next-state: frame sequencing, bit timing, holding-register management
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        // Mid-frame acceptance parks the byte; the last stop cycle may override below
        if (accept && (state_q != StIdle)) begin
            hold_d      = tx.i_Tx_Byte;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (accept) begin
                    shift_d = tx.i_Tx_Byte;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = StStart;
                    end else if (accept) begin
                        // Byte arriving on the final stop cycle starts immediately
                        shift_d     = tx.i_Tx_Byte;
                        hold_full_d = 1'b0;
                        state_d     = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Line value is decided from the next state so the output can be registered
        case (state_d)
            StStart: serial_d = 1'b0;
            StData:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset; reset wins over any acceptance
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            serial_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            serial_q    <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (87 and 2 clocks per bit) compared every cycle
// against a frame-position reference model, plus a behavioural line receiver.
module tb_uart_tx;

    localparam int unsigned Cpb0 = 87;
    localparam int unsigned Cpb1 = 2;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       dv  [2];
    logic [7:0] din [2];
    logic [3:0] obs [2];   // {ready, active, serial, done}

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;

    int         done_cnt  [2];
    int         last_done [2];
    int         rx_cnt    [2];
    int         rx_drop   [2];
    logic [7:0] last_rx   [2];

    // Reference model: frame position 0..10*C-1 plus a one-deep hold slot
    bit         m_busy [2];
    int         m_t    [2];
    logic [7:0] m_byte [2];
    logic [7:0] m_hold [2];
    bit         m_hf   [2];
    logic [7:0] sent_q0 [$];
    logic [7:0] sent_q1 [$];
    int         mc;
    bit         macc;

    uart_tx_if if87 ();
    uart_tx_if if2 ();

    assign if87.i_Tx_DV   = dv[0];
    assign if87.i_Tx_Byte = din[0];
    assign if2.i_Tx_DV    = dv[1];
    assign if2.i_Tx_Byte  = din[1];
    assign obs[0] = {if87.o_Tx_Ready, if87.o_Tx_Active, if87.o_Tx_Serial, if87.o_Tx_Done};
    assign obs[1] = {if2.o_Tx_Ready, if2.o_Tx_Active, if2.o_Tx_Serial, if2.o_Tx_Done};

    uart_tx #(.CLKS_PER_BIT(Cpb0)) u_dut87 (
        .i_Clock (clk),
        .i_Reset (rst[0]),
        .tx      (if87)
    );

    uart_tx #(.CLKS_PER_BIT(Cpb1)) u_dut2 (
        .i_Clock (clk),
        .i_Reset (rst[1]),
        .tx      (if2)
    );

    always #5 clk = ~clk;

    function automatic int cpb(input int g);
        return (g == 0) ? int'(Cpb0) : int'(Cpb1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_sent(input int g, input logic [7:0] b);
        if (g == 0) sent_q0.push_back(b);
        else        sent_q1.push_back(b);
    endtask

    task automatic drop_sent(input int g);
        if (g == 0 && sent_q0.size() > 0) void'(sent_q0.pop_back());
        if (g == 1 && sent_q1.size() > 0) void'(sent_q1.pop_back());
    endtask

    // Expected {ready, active, serial, done} from the frame position
    function automatic logic [3:0] model_out(input int g);
        int   c;
        int   k;
        logic s;
        c = cpb(g);
        s = 1'b1;
        if (m_busy[g]) begin
            k = m_t[g] / c;
            if (k == 0)      s = 1'b0;
            else if (k <= 8) s = m_byte[g][k-1];
        end
        return {~m_hf[g], m_busy[g], s, m_busy[g] && (m_t[g] == 10 * c - 1)};
    endfunction

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model update on each rising edge
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mc   = cpb(g);
            macc = dv[g] && !m_hf[g];
            if (rst[g]) begin
                if (m_busy[g]) drop_sent(g);
                m_busy[g] <= 1'b0;
                m_hf[g]   <= 1'b0;
                m_t[g]    <= 0;
            end else if (!m_busy[g]) begin
                if (macc) begin
                    m_busy[g] <= 1'b1;
                    m_t[g]    <= 0;
                    m_byte[g] <= din[g];
                    push_sent(g, din[g]);
                end
            end else if (m_t[g] == 10 * mc - 1) begin
                if (m_hf[g]) begin
                    m_byte[g] <= m_hold[g];
                    m_hf[g]   <= 1'b0;
                    m_t[g]    <= 0;
                    push_sent(g, m_hold[g]);
                end else if (macc) begin
                    m_byte[g] <= din[g];
                    m_t[g]    <= 0;
                    push_sent(g, din[g]);
                end else begin
                    m_busy[g] <= 1'b0;
                end
            end else begin
                m_t[g] <= m_t[g] + 1;
                if (macc) begin
                    m_hold[g] <= din[g];
                    m_hf[g]   <= 1'b1;
                end
            end
        end
    end

    // Per-cycle output comparison, sampled mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                check_eq((g == 0) ? "line87" : "line2", obs[g], model_out(g));
                if (obs[g][0]) begin
                    done_cnt[g]  = done_cnt[g] + 1;
                    last_done[g] = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_got(input int g, input logic [7:0] b, input logic stop);
        logic [7:0] e;
        if (rx_drop[g] > 0) begin
            rx_drop[g]--;
        end else begin
            check_eq("rx_pending", (g == 0) ? sent_q0.size() != 0 : sent_q1.size() != 0, 1);
            e = 8'h00;
            if (g == 0 && sent_q0.size() > 0) e = sent_q0.pop_front();
            if (g == 1 && sent_q1.size() > 0) e = sent_q1.pop_front();
            check_eq("rx_byte", b, e);
            check_eq("rx_stop", stop, 1);
            rx_cnt[g]++;
            last_rx[g] = b;
        end
    endtask

    // Behavioural receiver: mid-bit sampling after a detected start edge
    task automatic rx_run(input int g);
        int         c;
        logic [7:0] b;
        logic       stop;
        c = cpb(g);
        wait (chk_en);
        forever begin
            tick(1);
            if (obs[g][1] == 1'b0 && !rst[g]) begin
                tick(c / 2);
                if (obs[g][1] == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        tick(c);
                        b[i] = obs[g][1];
                    end
                    tick(c);
                    stop = obs[g][1];
                    rx_got(g, b, stop);
                end
            end
        end
    endtask

    task automatic send(input int g, input logic [7:0] b);
        dv[g]  = 1'b1;
        din[g] = b;
        tick(1);
        dv[g]  = 1'b0;
    endtask

    task automatic send_rdy(input int g, input logic [7:0] b);
        for (int i = 0; i < 2000 && !obs[g][3]; i++) tick(1);
        check_eq("rdy_seen", obs[g][3], 1);
        send(g, b);
    endtask

    task automatic wait_done(input int g, input int budget);
        int n0;
        n0 = done_cnt[g];
        for (int i = 0; i < budget && done_cnt[g] == n0; i++) tick(1);
        check_eq("done_seen", done_cnt[g] != n0, 1);
    endtask

    task automatic wait_idle(input int g, input int budget);
        for (int i = 0; i < budget && obs[g][3:2] != 2'b10; i++) tick(1);
        check_eq("idle_seen", obs[g][3:2], 2'b10);
        tick(2);
    endtask

    // Absolute time limit so a stuck run still ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed then randomized stimulus
    initial begin
        int acc;
        int d1;
        int d2;
        int dc;
        int r0;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; dv[g] = 1'b0; din[g] = 8'h00;
            done_cnt[g] = 0; last_done[g] = 0; rx_cnt[g] = 0; rx_drop[g] = 0;
        end
        fork
            rx_run(0);
            rx_run(1);
        join_none
        tick(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1'b1;
        check_eq("reset87", obs[0], 4'b1010);
        check_eq("reset2", obs[1], 4'b1010);

        // Single byte, done latency from acceptance
        acc = cyc;
        send(0, 8'h3F);
        wait_done(0, 1000);
        check_eq("single_lat", last_done[0] - acc, 870);
        wait_idle(0, 200);
        check_eq("single_rx", last_rx[0], 8'h3F);

        // Back-to-back frames
        send(0, 8'hA5);
        tick(100);
        send(0, 8'h5A);
        wait_done(0, 1000);
        d1 = last_done[0];
        check_eq("b2b_start", obs[0][2:1], 2'b10);
        wait_done(0, 1000);
        d2 = last_done[0];
        check_eq("b2b_period", d2 - d1, 870);
        wait_idle(0, 200);

        // Overflow: third byte dropped while holding register is full
        r0 = rx_cnt[0];
        send(0, 8'h11);
        tick(5);
        send(0, 8'h22);
        check_eq("ovf_ready", obs[0][3], 0);
        send(0, 8'hFF);
        wait_idle(0, 2000);
        tick(5);
        check_eq("ovf_count", rx_cnt[0] - r0, 2);
        check_eq("ovf_last", last_rx[0], 8'h22);

        // Reset during data bit 3 of 0x00
        send(0, 8'h00);
        tick(4 * Cpb0 + 40);
        rx_drop[0] = 1;
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        check_eq("rst_mid", obs[0], 4'b1010);
        dc = done_cnt[0];
        tick(12 * Cpb0);
        check_eq("rst_nodone", done_cnt[0] - dc, 0);

        // Reset beats a simultaneous byte strobe
        rst[0] = 1'b1; dv[0] = 1'b1; din[0] = 8'h77;
        tick(1);
        rst[0] = 1'b0; dv[0] = 1'b0;
        tick(3);
        check_eq("rst_prio", obs[0], 4'b1010);

        // Loopback sequence
        r0 = rx_cnt[0];
        send_rdy(0, 8'h00);
        send_rdy(0, 8'hFF);
        send_rdy(0, 8'h55);
        send_rdy(0, 8'h81);
        wait_idle(0, 4000);
        check_eq("loop_cnt", rx_cnt[0] - r0, 4);
        check_eq("loop_last", last_rx[0], 8'h81);

        // Minimum bit time
        acc = cyc;
        send(1, 8'hC3);
        wait_done(1, 100);
        check_eq("min_frame", last_done[1] - acc, 20);
        wait_idle(1, 50);
        check_eq("min_rx", last_rx[1], 8'hC3);

        // Randomized traffic, strobes may land while not ready
        for (int i = 0; i < 24; i++) begin
            send(0, 8'($urandom));
            tick($urandom_range(0, 1200));
        end
        for (int i = 0; i < 300; i++) begin
            send(1, 8'($urandom));
            tick($urandom_range(0, 30));
        end
        wait_idle(0, 3000);
        wait_idle(1, 100);
        tick(20);
        check_eq("left87", sent_q0.size(), 0);
        check_eq("left2", sent_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
